// File: rtl/m_sync_deglitch.sv
// m_sync_deglitch: level qualifier for an already-synchronized bit.
// A new level is accepted only after STABLE_CNT consecutive identical samples;
// accepted edges produce one-cycle rise/fall pulses, aborted qualifications
// bump a saturating glitch counter.
module m_sync_deglitch #(
  parameter int STABLE_CNT   = 4,
  parameter int GLITCH_CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_data,
  input  logic                    i_clr,
  output logic                    o_level,
  output logic                    o_rise,
  output logic                    o_fall,
  output logic [GLITCH_CNT_W-1:0] o_glitch_cnt
);

  localparam int CW = $clog2(STABLE_CNT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CNT - 1);

  if (STABLE_CNT < 1) begin : g_bad_stable_cnt
    $error("m_sync_deglitch: STABLE_CNT must be >= 1");
  end
  if (GLITCH_CNT_W < 1) begin : g_bad_glitch_cnt_w
    $error("m_sync_deglitch: GLITCH_CNT_W must be >= 1");
  end

  typedef enum logic [1:0] {
    ST_LO   = 2'd0,
    QUAL_HI = 2'd1,
    ST_HI   = 2'd2,
    QUAL_LO = 2'd3
  } state_t;

  state_t                  state, state_nx;
  logic [CW-1:0]           cnt, cnt_nx;
  logic                    level_nx, rise_nx, fall_nx;
  logic                    glitch;
  logic [GLITCH_CNT_W-1:0] gcnt_nx;

  // State, qualification counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_LO;
      cnt          <= '0;
      o_level      <= 1'b0;
      o_rise       <= 1'b0;
      o_fall       <= 1'b0;
      o_glitch_cnt <= '0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      o_level      <= level_nx;
      o_rise       <= rise_nx;
      o_fall       <= fall_nx;
      o_glitch_cnt <= gcnt_nx;
    end
  end

  // Next state; outputs are derived from the transition so they register
  // on the same edge that accepts the new level (no extra pipeline stage).
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    level_nx = o_level;
    rise_nx  = 1'b0;
    fall_nx  = 1'b0;
    glitch   = 1'b0;
    case (state)
      ST_LO: begin
        if (i_data) begin
          if (STABLE_CNT == 1) begin
            state_nx = ST_HI;
            level_nx = 1'b1;
            rise_nx  = 1'b1;
          end else begin
            state_nx = QUAL_HI;
            cnt_nx   = CW'(1);
          end
        end
      end
      QUAL_HI: begin
        if (!i_data) begin
          state_nx = ST_LO;
          cnt_nx   = '0;
          glitch   = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_nx = ST_HI;
          cnt_nx   = '0;
          level_nx = 1'b1;
          rise_nx  = 1'b1;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      ST_HI: begin
        if (!i_data) begin
          if (STABLE_CNT == 1) begin
            state_nx = ST_LO;
            level_nx = 1'b0;
            fall_nx  = 1'b1;
          end else begin
            state_nx = QUAL_LO;
            cnt_nx   = CW'(1);
          end
        end
      end
      QUAL_LO: begin
        if (i_data) begin
          state_nx = ST_HI;
          cnt_nx   = '0;
          glitch   = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_nx = ST_LO;
          cnt_nx   = '0;
          level_nx = 1'b0;
          fall_nx  = 1'b1;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      default: begin
        state_nx = ST_LO;
        cnt_nx   = '0;
      end
    endcase
  end

  // Saturating glitch counter; a coincident clear takes priority.
  always_comb begin
    gcnt_nx = o_glitch_cnt;
    if (i_clr) begin
      gcnt_nx = '0;
    end else if (glitch && !(&o_glitch_cnt)) begin
      gcnt_nx = o_glitch_cnt + GLITCH_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_m_sync_deglitch.sv
// Testbench for m_sync_deglitch: three instances (STABLE_CNT=4/W=8,
// STABLE_CNT=4/W=2, STABLE_CNT=1/W=8) share the stimulus and are checked
// against a run-length reference model.
module tb_m_sync_deglitch;

  logic       clk, rst, d, clr;
  logic       la, ra, fa;
  logic [7:0] ga;
  logic       lb, rb, fb;
  logic [1:0] gb;
  logic       lc, rc, fc;
  logic [7:0] gc;

  int checks = 0;
  int fails  = 0;

  // Reference model state per instance.
  int n_tab[3] = '{4, 4, 1};
  int gmax[3]  = '{255, 3, 255};
  bit m_level[3];
  bit m_rise[3];
  bit m_fall[3];
  int m_run[3];
  int m_g[3];

  m_sync_deglitch #(.STABLE_CNT(4), .GLITCH_CNT_W(8)) u_a (
    .clk(clk), .rst(rst), .i_data(d), .i_clr(clr),
    .o_level(la), .o_rise(ra), .o_fall(fa), .o_glitch_cnt(ga));

  m_sync_deglitch #(.STABLE_CNT(4), .GLITCH_CNT_W(2)) u_b (
    .clk(clk), .rst(rst), .i_data(d), .i_clr(clr),
    .o_level(lb), .o_rise(rb), .o_fall(fb), .o_glitch_cnt(gb));

  m_sync_deglitch #(.STABLE_CNT(1), .GLITCH_CNT_W(8)) u_c (
    .clk(clk), .rst(rst), .i_data(d), .i_clr(clr),
    .o_level(lc), .o_rise(rc), .o_fall(fc), .o_glitch_cnt(gc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [10:0] obs_vec(int i);
    case (i)
      0:       return {la, ra, fa, ga};
      1:       return {lb, rb, fb, 6'b0, gb};
      default: return {lc, rc, fc, gc};
    endcase
  endfunction

  function automatic logic [10:0] exp_vec(int i);
    return {m_level[i], m_rise[i], m_fall[i], 8'(m_g[i])};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_level[i] = 1'b0; m_rise[i] = 1'b0; m_fall[i] = 1'b0;
      m_run[i] = 0; m_g[i] = 0;
    end
  endtask

  // Advance one clock edge and update the model from the sampled inputs;
  // returns 1 ns after the edge.
  task automatic clk_step();
    bit glitch;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      for (int i = 0; i < 3; i++) begin
        glitch = 1'b0;
        m_rise[i] = 1'b0;
        m_fall[i] = 1'b0;
        if (d == m_level[i]) begin
          if (m_run[i] > 0) glitch = 1'b1;
          m_run[i] = 0;
        end else begin
          m_run[i]++;
          if (m_run[i] == n_tab[i]) begin
            m_level[i] = d;
            if (d) m_rise[i] = 1'b1; else m_fall[i] = 1'b1;
            m_run[i] = 0;
          end
        end
        if (clr) m_g[i] = 0;
        else if (glitch && m_g[i] < gmax[i]) m_g[i]++;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; d = 1'b0; clr = 1'b0;
    model_reset();
    for (int k = 0; k < 5; k++) begin
      d = 1'($urandom);
      clk_step();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs_vec(i) !== 11'd0) begin
          fails++;
          $display("FAIL reset_hold dut%0d got=%h exp=%h", i, obs_vec(i), 11'd0);
        end
      end
    end
    rst = 1'b0; d = 1'b0;
    for (int k = 0; k < 3; k++) begin
      clk_step();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs_vec(i) !== exp_vec(i)) begin
          fails++;
          $display("FAIL reset_release dut%0d got=%h exp=%h", i, obs_vec(i), exp_vec(i));
        end
      end
    end
  endtask

  task automatic test_clean_rise_fall();
    for (int ph = 0; ph < 2; ph++) begin
      d = (ph == 0);
      for (int k = 1; k <= 10; k++) begin
        clk_step();
        checks++;
        if (ph == 0 && (la !== (k >= 4) || ra !== (k == 4) || fa !== 1'b0)) begin
          fails++;
          $display("FAIL clean_rise edge%0d got l=%b r=%b f=%b exp l=%b r=%b f=0",
                   k, la, ra, fa, (k >= 4), (k == 4));
        end
        if (ph == 1 && (la !== (k < 4) || fa !== (k == 4) || ra !== 1'b0)) begin
          fails++;
          $display("FAIL clean_fall edge%0d got l=%b r=%b f=%b exp l=%b r=0 f=%b",
                   k, la, ra, fa, (k < 4), (k == 4));
        end
        for (int i = 0; i < 3; i++) begin
          checks++;
          if (obs_vec(i) !== exp_vec(i)) begin
            fails++;
            $display("FAIL clean_model dut%0d got=%h exp=%h", i, obs_vec(i), exp_vec(i));
          end
        end
      end
    end
  endtask

  task automatic test_glitch();
    bit pat[];
    // 3 high, back low (glitch from ST_LO); then accept high, 2 low, back high.
    pat = '{1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 0, 0, 1, 1, 1};
    clr = 1'b1; d = 1'b0; clk_step(); clr = 1'b0;
    for (int k = 0; k < pat.size(); k++) begin
      d = pat[k];
      clk_step();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs_vec(i) !== exp_vec(i)) begin
          fails++;
          $display("FAIL glitch_model dut%0d step%0d got=%h exp=%h", i, k, obs_vec(i), exp_vec(i));
        end
      end
      if (k == 3) begin
        checks++;
        if (ga !== 8'd1 || la !== 1'b0 || ra !== 1'b0) begin
          fails++;
          $display("FAIL glitch_lo got cnt=%0d l=%b r=%b exp cnt=1 l=0 r=0", ga, la, ra);
        end
      end
      if (k == 12) begin
        checks++;
        if (ga !== 8'd2 || la !== 1'b1 || fa !== 1'b0) begin
          fails++;
          $display("FAIL glitch_hi got cnt=%0d l=%b f=%b exp cnt=2 l=1 f=0", ga, la, fa);
        end
      end
    end
  endtask

  task automatic test_saturation();
    int  exp_seq[5] = '{1, 2, 3, 3, 3};
    bit  lv;
    lv = m_level[1];
    clr = 1'b1; d = lv; clk_step(); clr = 1'b0;
    for (int g = 0; g < 6; g++) begin
      d = ~lv; clk_step();
      d = ~lv; clk_step();
      d = lv;
      clr = (g == 5);
      clk_step();
      clr = 1'b0;
      checks++;
      if (g < 5 && gb !== 2'(exp_seq[g])) begin
        fails++;
        $display("FAIL saturate glitch%0d got=%0d exp=%0d", g + 1, gb, exp_seq[g]);
      end
      if (g == 5 && gb !== 2'd0) begin
        fails++;
        $display("FAIL clear_wins got=%0d exp=0", gb);
      end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs_vec(i) !== exp_vec(i)) begin
          fails++;
          $display("FAIL saturate_model dut%0d got=%h exp=%h", i, obs_vec(i), exp_vec(i));
        end
      end
    end
  endtask

  task automatic test_reset_mid_qual();
    d = 1'b0;
    for (int k = 0; k < 5; k++) clk_step();
    clr = 1'b1; clk_step(); clr = 1'b0;
    d = 1'b1;
    clk_step();
    clk_step();
    #3 rst = 1'b1;
    #1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs_vec(i) !== 11'd0) begin
        fails++;
        $display("FAIL async_reset dut%0d got=%h exp=%h", i, obs_vec(i), 11'd0);
      end
    end
    clk_step();
    clk_step();
    rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      clk_step();
      checks++;
      if (ra !== (k == 4) || ga !== 8'd0) begin
        fails++;
        $display("FAIL restart_rise edge%0d got r=%b cnt=%0d exp r=%b cnt=0", k, ra, ga, (k == 4));
      end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs_vec(i) !== exp_vec(i)) begin
          fails++;
          $display("FAIL restart_model dut%0d got=%h exp=%h", i, obs_vec(i), exp_vec(i));
        end
      end
    end
  endtask

  task automatic test_stable1();
    d = 1'b0;
    for (int k = 0; k < 5; k++) clk_step();
    d = 1'b1; clk_step();
    checks++;
    if (rc !== 1'b1 || lc !== 1'b1 || fc !== 1'b0) begin
      fails++;
      $display("FAIL s1_rise got l=%b r=%b f=%b exp l=1 r=1 f=0", lc, rc, fc);
    end
    d = 1'b0; clk_step();
    checks++;
    if (fc !== 1'b1 || lc !== 1'b0 || rc !== 1'b0 || gc !== 8'd0) begin
      fails++;
      $display("FAIL s1_fall got l=%b r=%b f=%b cnt=%0d exp l=0 r=0 f=1 cnt=0", lc, rc, fc, gc);
    end
  endtask

  task automatic test_random();
    int run;
    bit v;
    v = 1'b0;
    for (int s = 0; s < 300; s++) begin
      v   = ~v;
      run = $urandom_range(1, 6);
      for (int k = 0; k < run; k++) begin
        d   = v;
        clr = ($urandom_range(0, 15) == 0);
        clk_step();
        for (int i = 0; i < 3; i++) begin
          checks++;
          if (obs_vec(i) !== exp_vec(i)) begin
            fails++;
            $display("FAIL random_model dut%0d seg%0d got=%h exp=%h", i, s, obs_vec(i), exp_vec(i));
          end
        end
        checks++;
        if ((ra && fa) || (rb && fb) || (rc && fc)) begin
          fails++;
          $display("FAIL pulse_excl got a=%b%b b=%b%b c=%b%b exp no rise+fall together",
                   ra, fa, rb, fb, rc, fc);
        end
      end
    end
    clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clean_rise_fall();
    test_glitch();
    test_saturation();
    test_reset_mid_qual();
    test_stable1();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
